// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: applies one power-of-two stage per cycle (16/8/4/2/1),
// then pulses data_resultRDY for one cycle using the multdiv start/ready/exception handshake.
module shift_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_shift,
    input  logic [1:0]  op,
    input  logic [31:0] data_operand,
    input  logic [4:0]  shamt,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic        busy
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   acc, acc_n;
    logic [SHAMT_W-1:0]  rem, rem_n;
    logic [1:0]          op_q, op_n;
    logic                exc_q, exc_n;

    logic [SHAMT_W-1:0]  step;
    logic [DATA_W-1:0]   shifted;

    // Largest remaining power-of-two stage; one-hot, so its value is also the shift distance.
    always_comb begin
        step = '0;
        if (rem[4])      step = SHAMT_W'(16);
        else if (rem[3]) step = SHAMT_W'(8);
        else if (rem[2]) step = SHAMT_W'(4);
        else if (rem[1]) step = SHAMT_W'(2);
        else if (rem[0]) step = SHAMT_W'(1);
    end

    always_comb begin
        shifted = '0;
        case (op_q)
            OP_SLL:  shifted = acc << step;
            OP_SRA:  shifted = DATA_W'($signed(acc) >>> step);
            default: shifted = acc >> step;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= '0;
            exc_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            rem   <= rem_n;
            op_q  <= op_n;
            exc_q <= exc_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        op_n    = op_q;
        exc_n   = exc_q;
        case (state)
            SHIFT: begin
                acc_n   = shifted;
                rem_n   = rem & ~step;
                state_n = (rem_n == '0) ? DONE : SHIFT;
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                if (ctrl_shift) begin
                    acc_n   = data_operand;
                    rem_n   = shamt;
                    op_n    = op;
                    exc_n   = (op == OP_ILL);
                    state_n = ((op == OP_ILL) || (shamt == '0)) ? DONE : SHIFT;
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign data_result    = acc;
    assign data_resultRDY = (state == DONE);
    assign busy           = (state == SHIFT);
    assign data_exception = exc_q & data_resultRDY;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle 32-bit shift unit for the processor's execute stage, used for `sll`, `sra` and `srl` instead of a single-cycle 5-level barrel shifter. It accepts an operand and a 5-bit shift amount with a start pulse. Each cycle it applies one fixed power-of-two shift stage (16, 8, 4, 2 or 1), then signals completion with a one-cycle ready pulse. It uses the same start/ready/exception handshake as the multdiv unit, so the pipeline stall logic treats both units identically.

## Interface
- No parameters. Data width is fixed at 32 and shift amount width at 5.
- `clock`  in  1  — sole clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset. Low forces the reset state immediately.
- `ctrl_shift`  in  1  — start request, sampled on the rising edge.
- `op`  in  2  — operation: 00 = sll, 01 = sra, 10 = srl, 11 = illegal.
- `data_operand`  in  32  — value to shift, sampled with `ctrl_shift`.
- `shamt`  in  5  — shift amount 0–31, sampled with `ctrl_shift`.
- `data_result`  out  32  — shifted result. Valid while `data_resultRDY` = 1.
- `data_resultRDY`  out  1  — high for exactly one cycle when the result is valid.
- `data_exception`  out  1  — high together with `data_resultRDY` when `op` = 11.
- `busy`  out  1  — high while in SHIFT.

## Operation
- **State registers:** `state` (IDLE, SHIFT, DONE), `acc[31:0]`, `rem[4:0]`, `op_q[1:0]`, `exc_q`.
- **Reset:** state = IDLE; `acc`, `rem`, `op_q` = 0; `exc_q` = 0. All outputs are therefore 0: `data_result` = 0, `data_resultRDY` = 0, `data_exception` = 0, `busy` = 0.
- **Output decode:**
  - `data_resultRDY` = (state == DONE)
  - `busy` = (state == SHIFT)
  - `data_result` = `acc`
  - `data_exception` = `exc_q` & `data_resultRDY`
- **Accept:** a start is accepted when `ctrl_shift` = 1 and state is IDLE or DONE. On accept:
  - `acc` ← `data_operand`, `rem` ← `shamt`, `op_q` ← `op`, `exc_q` ← (`op` == 11).
  - Next state is DONE if `op` == 11 or `shamt` == 0; otherwise SHIFT.
  - An illegal op returns the operand unchanged, with the exception flag set.
- **Ignored start:** `ctrl_shift` in SHIFT is ignored; no queuing.
- **SHIFT step (each edge):**
  - k = index of the highest set bit of `rem`; apply a shift by 2^k to `acc` and clear bit k of `rem`.
  - sll: zero-fill from the LSB.
  - srl: zero-fill from the MSB.
  - sra: fill the vacated upper 2^k bits with `acc[31]`.
  - Go to DONE when the updated `rem` == 0; otherwise stay in SHIFT.
- **DONE:** returns to IDLE on the next edge unless a new accept occurs, which gives back-to-back operation.
- **Result hold:** `data_result` holds its value through IDLE until the next accept. Consumers use it only while `data_resultRDY` is high.
- **Reset mid-operation:** immediate return to IDLE with all registers cleared. No ready pulse is produced for the aborted operation.

## Timing
- Start sampled at edge E0 (cycle 0). With p = popcount(`shamt`), `data_resultRDY` is high during cycle p+1 only.
- Latency examples:
  - `shamt` = 0 → 1 cycle.
  - `shamt` = 16 → 2 cycles.
  - `shamt` = 31 → 6 cycles, the maximum.
  - Illegal op → 1 cycle.
- `busy` is high during cycles 1..p when p > 0, and never high for p = 0 or an illegal op.
- Throughput: a new start can be accepted in the DONE cycle. Its result pulse then follows p'+1 cycles later, with no idle gap.
- All outputs are functions of registered state only; no input-to-output combinational path.

## Test plan
- **Reset:** assert `reset` = 0 mid-SHIFT (sra, 0x80000000, `shamt` = 31, after 2 steps) → all outputs 0 immediately. No `data_resultRDY` ever follows. A later start with sll 0x1, `shamt` = 4 → result 0x00000010 in cycle 2.
- **sra sweep:** `data_operand` = 0x80000000, `shamt` = 31 → result 0xFFFFFFFF in cycle 6. `busy` high in cycles 1–5. Next, `shamt` = 2 → 0xE0000000 in cycle 2.
- **srl vs sra:** `data_operand` = 0xF0000000, `shamt` = 5:
  - srl → 0x07800000, ready in cycle 3.
  - sra → 0xFF800000, ready in cycle 3.
- **Zero shift and illegal op:**
  - sll 0x12345678, `shamt` = 0 → 0x12345678 in cycle 1, `data_exception` = 0.
  - `op` = 11 with 0xDEADBEEF, `shamt` = 7 → 0xDEADBEEF in cycle 1 with `data_exception` = 1.
- **Busy-ignore and back-to-back:**
  - Start sll 0x1, `shamt` = 3. Pulse `ctrl_shift` in cycle 1 with different data → ignored; result 0x00000008 in cycle 3.
  - Start again in that DONE cycle with srl 0x100, `shamt` = 8 → 0x00000001 two cycles later.
- **Random compare:** 10,000 random `op` (00/01/10), operand and `shamt`, issued back-to-back → every result matches the `<<`, `>>>` and `>>` reference models. Each ready pulse lands exactly popcount(`shamt`)+1 cycles after its start.
